// File: rtl/bomb_pkg.sv
// bomb_pkg: bomb FSM states, explosion geometry shared with box_top, and position helpers.
package bomb_pkg;
  typedef enum logic [1:0] {IDLE, FUSE, BLAST} state_e;
  localparam int TILE    = 16;
  localparam int ARM_NEG = 48;
  localparam int ARM_POS = 63;
  localparam int E_MAX   = 1008;
  // Round to the nearest tile corner; the bomb must stay fully on a 1024-wide grid.
  function automatic logic [9:0] tile_align(input logic [9:0] p);
    logic [10:0] s;
    s = ({1'b0, p} + 11'd8) & ~11'd15;
    return (s > 11'(E_MAX)) ? 10'(E_MAX) : s[9:0];
  endfunction
  function automatic logic in_span(input logic signed [11:0] p, input logic signed [11:0] lo,
                                   input logic signed [11:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction
endpackage

// File: rtl/blast_region.sv
// blast_region: combinational plus-shaped blast hit test around a tile-aligned origin.
module blast_region
  import bomb_pkg::*;
(
  input  logic [9:0] e_x,
  input  logic [9:0] e_y,
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic       hit
);
  localparam logic signed [11:0] T1  = 12'(TILE - 1);
  localparam logic signed [11:0] NEG = 12'(ARM_NEG);
  localparam logic signed [11:0] POS = 12'(ARM_POS);
  logic signed [11:0] x, y, ex, ey, lo_x, lo_y;
  logic h_arm, v_arm;
  assign x    = $signed({2'b00, px});
  assign y    = $signed({2'b00, py});
  assign ex   = $signed({2'b00, e_x});
  assign ey   = $signed({2'b00, e_y});
  assign lo_x = (ex - NEG < 0) ? 12'sd0 : ex - NEG;
  assign lo_y = (ey - NEG < 0) ? 12'sd0 : ey - NEG;
  assign h_arm = in_span(x, lo_x, ex + POS) && in_span(y, ey, ey + T1);
  assign v_arm = in_span(x, ex, ex + T1) && in_span(y, lo_y, ey + POS);
  assign hit = h_arm || v_arm;
endmodule

// File: rtl/bomb_ctrl.sv
// bomb_ctrl: bomb drop/fuse/blast lifecycle, detonation pulse and per-pixel bomb/blast flags.
// Optional REMOTE_DETONATE_EN adds a detonate input that ends the fuse early.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES  = 180,
  parameter int BLAST_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       drop,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic [9:0] e_x,
  output logic [9:0] e_y,
  output logic       explosion_SCEN,
  output logic       bomb_active,
  output logic       exploding,
  output logic       bomb_on,
  output logic       explosion_on
`ifdef REMOTE_DETONATE_EN
  ,
  input  logic       detonate
`endif
);
  localparam int FW = $clog2(FUSE_FRAMES + 1);
  localparam int BW = $clog2(BLAST_FRAMES + 1);
  state_e state_q, state_d;
  logic [FW-1:0] fuse_q, fuse_d;
  logic [BW-1:0] blast_q, blast_d;
  logic [9:0] ex_q, ex_d, ey_q, ey_d;
  logic scen_q, bon_q, eon_q;
  logic fire, hit, in_tile;
`ifdef REMOTE_DETONATE_EN
  assign fire = detonate || (frame_tick && fuse_q == FW'(FUSE_FRAMES - 1));
`else
  assign fire = frame_tick && fuse_q == FW'(FUSE_FRAMES - 1);
`endif
  always_comb begin
    state_d = state_q;
    fuse_d  = fuse_q;
    blast_d = blast_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    unique case (state_q)
      IDLE: if (drop) begin
        state_d = FUSE;
        fuse_d  = '0;
        ex_d    = tile_align(b_x);
        ey_d    = tile_align(b_y);
      end
      FUSE: if (fire) begin
        state_d = BLAST;
        blast_d = '0;
      end else if (frame_tick) fuse_d = fuse_q + FW'(1);
      BLAST: if (frame_tick) begin
        state_d = (blast_q == BW'(BLAST_FRAMES - 1)) ? IDLE : BLAST;
        blast_d = blast_q + BW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  assign in_tile = (v_x >= ex_q) && ({1'b0, v_x} <= {1'b0, ex_q} + 11'(TILE - 1)) &&
                   (v_y >= ey_q) && ({1'b0, v_y} <= {1'b0, ey_q} + 11'(TILE - 1));
  blast_region u_region (
    .e_x(ex_q),
    .e_y(ey_q),
    .px (v_x),
    .py (v_y),
    .hit(hit)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fuse_q  <= '0;
      blast_q <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      scen_q  <= 1'b0;
      bon_q   <= 1'b0;
      eon_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fuse_q  <= fuse_d;
      blast_q <= blast_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      scen_q  <= (state_q == FUSE) && (state_d == BLAST);
      bon_q   <= (state_q == FUSE) && in_tile;
      eon_q   <= (state_q == BLAST) && hit;
    end
  end
  assign e_x            = ex_q;
  assign e_y            = ey_q;
  assign explosion_SCEN = scen_q;
  assign bomb_active    = state_q != IDLE;
  assign exploding      = state_q == BLAST;
  assign bomb_on        = bon_q;
  assign explosion_on   = eon_q;
endmodule
